// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, FSM encoding and the M/W entry layout used by
// the memory-access stage and its M/W pipeline register.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One M/W pipeline entry as seen by writeback.
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem_data;
    logic [REG_W-1:0]  reg_dst;
    logic              mem_to_reg;
    logic              reg_write;
  } mw_t;

endpackage

// File: rtl/mem_stage_mw_reg.sv
// dffe_ref: W-bit D flip-flop with enable and asynchronous active-low clear.
//   clk, rst_n   clock / async clear
//   en_i         load enable
//   d_i / q_o    data in / registered data out
//
// mw_reg: M/W pipeline register assembled from dffe_ref cells. When bubble_i
// is high the register loads an all-zero entry instead of d_i.
//   clk, rst_n   clock / async clear
//   bubble_i     load a bubble this cycle
//   d_i          incoming M/W entry
//   q_o          registered M/W entry
module dffe_ref #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

module mw_reg
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bubble_i,
  input  mw_t  d_i,
  output mw_t  q_o
);

  mw_t               d_sel;
  logic [DATA_W-1:0] q_alu;
  logic [DATA_W-1:0] q_mem;
  logic [REG_W-1:0]  q_dst;
  logic              q_m2r;
  logic              q_rw;

  // A bubble is an all-zero entry: no register write, ALU select, $r0.
  assign d_sel = bubble_i ? '0 : d_i;

  // The stage advances every clock; stalls are expressed as bubbles.
  dffe_ref #(.W(DATA_W)) u_alu (.clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(d_sel.alu),        .q_o(q_alu));
  dffe_ref #(.W(DATA_W)) u_mem (.clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(d_sel.mem_data),   .q_o(q_mem));
  dffe_ref #(.W(REG_W))  u_dst (.clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(d_sel.reg_dst),    .q_o(q_dst));
  dffe_ref #(.W(1))      u_m2r (.clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(d_sel.mem_to_reg), .q_o(q_m2r));
  dffe_ref #(.W(1))      u_rw  (.clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(d_sel.reg_write),  .q_o(q_rw));

  assign q_o = '{alu: q_alu, mem_data: q_mem, reg_dst: q_dst, mem_to_reg: q_m2r, reg_write: q_rw};

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Consumes the X/M register, runs a
// request/acknowledge transaction with data memory for loads and stores,
// stalls upstream while the transaction is outstanding and feeds writeback
// through the M/W register.
//   clock, reset            clock / async active-low reset
//   *_from_xm               X/M register outputs
//   dmem_req/we/addr/wdata  registered memory request, held until ack
//   dmem_ack, dmem_rdata    one-cycle completion pulse with read data
//   stall_out               freezes X/M and earlier stages
//   *_from_mw               M/W register outputs
//   mem_err                 sticky request-timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] aluOut_from_xm,
  input  logic [DATA_W-1:0] dataB_from_xm,
  input  logic [REG_W-1:0]  regDst_from_xm,
  input  logic              MemWrite_from_xm,
  input  logic              MemToReg_from_xm,
  input  logic              RegWrite_from_xm,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic [DATA_W-1:0] aluOut_from_mw,
  output logic [DATA_W-1:0] memData_from_mw,
  output logic [REG_W-1:0]  regDst_from_mw,
  output logic              MemToReg_from_mw,
  output logic              RegWrite_from_mw,
  output logic              mem_err
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                memop;
  logic                bubble;
  mw_t                 mw_d, mw_q;

  assign memop = MemWrite_from_xm | MemToReg_from_xm;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    stall_out = 1'b0;
    bubble    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (memop) begin
          stall_out = 1'b1;
          bubble    = 1'b1;
          req_d     = 1'b1;
          // A combined store+load issues a write; read data is still taken.
          we_d      = MemWrite_from_xm;
          addr_d    = aluOut_from_xm[ADDR_W-1:0];
          wdata_d   = dataB_from_xm;
          state_d   = REQ;
        end
      end
      REQ: begin
        stall_out = 1'b1;
        bubble    = 1'b1;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // cnt_q counts completed unacknowledged REQ cycles before this one.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            req_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: every register here is a small control/data flop, so all of them
  // take the async reset; there is no storage array that would need it left off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_err    = err_q;

  // Memory data only reaches writeback in DONE; plain ALU ops carry zero.
  // $r0 is never written, whatever the instruction claims.
  assign mw_d = '{
    alu:        aluOut_from_xm,
    mem_data:   (state_q == DONE) ? rdata_q : '0,
    reg_dst:    regDst_from_xm,
    mem_to_reg: MemToReg_from_xm,
    reg_write:  RegWrite_from_xm & (regDst_from_xm != '0)
  };

  mw_reg u_mw_reg (
    .clk      (clock),
    .rst_n    (reset),
    .bubble_i (bubble),
    .d_i      (mw_d),
    .q_o      (mw_q)
  );

  assign aluOut_from_mw   = mw_q.alu;
  assign memData_from_mw  = mw_q.mem_data;
  assign regDst_from_mw   = mw_q.reg_dst;
  assign MemToReg_from_mw = mw_q.mem_to_reg;
  assign RegWrite_from_mw = mw_q.reg_write;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access (M) stage of the 5-stage pipeline; the consumer end of the X/M pipeline register.
- Takes the X/M outputs (ALU result, store data, destination register, MemWrite/MemToReg/RegWrite) and runs a request/acknowledge transaction with the data memory for loads and stores.
- Drives a stall back to the upstream pipeline registers (X/M, D/X, F/D) while a transaction is outstanding.
- Contains the M/W pipeline register that feeds writeback, and inserts bubbles while stalled.

Parameters:
ADDR_W, 12, data-memory word-address width; dmem_addr = aluOut_from_xm[ADDR_W-1:0]
TIMEOUT, 255, maximum REQ cycles without dmem_ack before abort (8-bit counter)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
aluOut_from_xm  input  32  ALU result / effective address from X/M
dataB_from_xm  input  32  store data from X/M
regDst_from_xm  input  5  destination register from X/M
MemWrite_from_xm  input  1  store request
MemToReg_from_xm  input  1  load request; writeback selects memory data
RegWrite_from_xm  input  1  instruction writes the register file
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1=write, 0=read; valid while dmem_req
dmem_addr  output  ADDR_W  word address; valid while dmem_req
dmem_wdata  output  32  store data; valid while dmem_req
dmem_ack  input  1  one-cycle completion pulse
dmem_rdata  input  32  read data; valid in the dmem_ack cycle
stall_out  output  1  freezes upstream registers; drives the stall input of X/M and earlier stages
aluOut_from_mw  output  32  M/W ALU result
memData_from_mw  output  32  M/W load data
regDst_from_mw  output  5  M/W destination register
MemToReg_from_mw  output  1  M/W writeback select
RegWrite_from_mw  output  1  M/W register-file write enable
mem_err  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - All M/W outputs 0; mem_err=0; timeout counter 0.
- memop = MemWrite_from_xm | MemToReg_from_xm.
- Non-memory instruction (memop=0, state IDLE):
  - stall_out=0; M/W captures X/M values every clock.
  - memData_from_mw=0.
  - Latency X/M to M/W is 1 cycle.
- FSM states: IDLE, REQ, DONE.
  - IDLE, memop=1: stall_out=1. Latch dmem_addr, dmem_wdata, and dmem_we=MemWrite_from_xm into request registers. Next state REQ. M/W loads a bubble (RegWrite=0, MemToReg=0, regDst=0, data 0).
  - REQ: dmem_req=1, stall_out=1, M/W loads a bubble. On dmem_ack: capture dmem_rdata into rdata_q and go to DONE. Otherwise increment the counter; when it reaches TIMEOUT, set mem_err=1, force rdata_q=0, and go to DONE.
  - DONE: dmem_req=0, stall_out=0. M/W captures the X/M instruction with memData=rdata_q. Next state IDLE; counter cleared.
- Minimum load/store latency is 3 cycles (IDLE, REQ with ack in its first cycle, DONE).
- Back-to-back memory ops: after DONE, the next X/M instruction is seen in IDLE, so every memory op pays the full latency.
- Request outputs (dmem_req, dmem_we, dmem_addr, dmem_wdata) are registered and stable for the whole of REQ.
- dmem_ack while in IDLE or DONE is ignored; it has no state change and no data capture.
- MemWrite and MemToReg both 1: the write takes precedence (dmem_we=1); rdata_q is still captured on ack.
- regDst_from_xm=0: RegWrite_from_mw is forced to 0 ($r0 is never written).
- Reset mid-transaction: dmem_req drops immediately and state returns to IDLE; an ack arriving after reset is released is ignored.
- mem_err is sticky and clears only on reset.

Decomposition:
- Shared package: DATA_W=32, REG_W=5, and FSM encodings IDLE=2'd0, REQ=2'd1, DONE=2'd2.
- One sub-module, mw_reg: M/W pipeline register built from dffe_ref cells.
  - Inputs: d-side values, a load-bubble select, and reset.
  - mem_stage supplies the FSM, the request registers, rdata_q, and the timeout counter.

Test Plan:
- ALU op: aluOut=0x0000_0ABC, regDst=5, RegWrite=1, memop=0 -> next cycle aluOut_from_mw=0xABC, RegWrite_from_mw=1, stall_out=0 throughout.
- Load: aluOut=0x0000_0010, MemToReg=1, RegWrite=1, regDst=3; memory acks in the 1st REQ cycle with 0xDEADBEEF -> dmem_addr=0x010, dmem_we=0; stall_out high 2 cycles; M/W shows regDst=3, memData=0xDEADBEEF, MemToReg=1 after the DONE edge; bubbles before that.
- Store with ack after 4 REQ cycles: aluOut=0x20, dataB=0x1234 -> dmem_req high exactly 4 cycles, dmem_we=1, dmem_wdata=0x1234; stall_out high 5 cycles; RegWrite_from_mw=0.
- Timeout: load with no ack -> after 255 REQ cycles mem_err=1, memData_from_mw=0, FSM returns to IDLE; mem_err stays 1 on later ops.
- Reset (reset=0) asserted in the 2nd REQ cycle -> dmem_req=0, stall_out=0, all M/W outputs 0 immediately; an ack pulse 1 cycle after release causes no M/W change.
- Stray ack in IDLE plus a regDst=0 write -> no state change; RegWrite_from_mw=0.
